// File: rtl/aes_block_loader.sv
// Word-stream loader for the AES-128 core: assembles key and plaintext into [0:127] buses.
// Optional CBC chaining with fb_cipher feedback is enabled by defining AES_LOADER_CBC_EN.
module aes_block_loader #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_is_key,
  output logic [0:127]     plain_text,
  output logic [0:127]     key,
  output logic             key_valid,
  output logic             blk_valid,
  input  logic             blk_ready,
  input  logic [0:127]     fb_cipher,
  output logic [CNT_W-1:0] blk_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t      state, state_next;
  logic [1:0]  key_cnt, data_cnt;
  logic        key_xfer, data_xfer, blk_xfer;
  logic [31:0] data_word;

  assign key_xfer  = in_valid & in_ready & in_is_key;
  assign data_xfer = in_valid & in_ready & ~in_is_key;
  assign blk_xfer  = blk_valid & blk_ready;

`ifdef AES_LOADER_CBC_EN
  logic [0:127] chain;

  // A fresh key restarts the chain, so the first block after it is plain ECB.
  always_ff @(posedge clk) begin
    if (rst)                              chain <= '0;
    else if (key_xfer && key_cnt == 2'd0) chain <= '0;
    else if (blk_xfer)                    chain <= fb_cipher;
  end

  assign data_word = in_data ^ chain[{data_cnt, 5'b0} +: 32];
`else
  logic unused_fb;
  assign unused_fb = ^fb_cipher;
  assign data_word = in_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    blk_valid  = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (data_xfer && data_cnt == 2'd3) state_next = HOLD;
      end
      HOLD: begin
        // Only a still-incomplete key may be loaded while a block is held.
        in_ready  = in_is_key & ~key_valid;
        blk_valid = key_valid;
        if (blk_xfer) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt    <= '0;
      data_cnt   <= '0;
      key_valid  <= 1'b0;
      key        <= '0;
      plain_text <= '0;
      blk_count  <= '0;
    end else begin
      if (key_xfer) begin
        key[{key_cnt, 5'b0} +: 32] <= in_data;
        key_cnt <= key_cnt + 2'd1;
        if (key_cnt == 2'd0) key_valid <= 1'b0;
        if (key_cnt == 2'd3) key_valid <= 1'b1;
      end
      if (data_xfer) begin
        plain_text[{data_cnt, 5'b0} +: 32] <= data_word;
        data_cnt <= data_cnt + 2'd1;
      end
      if (blk_xfer) blk_count <= blk_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed self-checking bench for aes_block_loader (ECB default, CBC with AES_LOADER_CBC_EN).
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_is_key = 1'b0;
  logic [0:127] plain_text;
  logic [0:127] key;
  logic         key_valid;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic [0:127] fb_cipher = '0;
  logic [15:0]  blk_count;

  localparam logic [127:0] K   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT2 = 128'ha0a1a2a3b0b1b2b3c0c1c2c3d0d1d2d3;
  localparam logic [127:0] PT4 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] PT5 = 128'hcafef00d0badc0de1234567889abcdef;
  localparam logic [127:0] K4  = 128'hdeadbeef05060708090a0b0c0d0e0f10;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  aes_block_loader #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_is_key(in_is_key), .plain_text(plain_text),
    .key(key), .key_valid(key_valid), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .fb_cipher(fb_cipher), .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_is_key = 1'b0; in_data = 32'hffffffff;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_word(input logic k, input logic [31:0] d);
    int unsigned n = 0;
    in_valid = 1'b1; in_is_key = k; in_data = d;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("word_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_words(input logic k, input logic [127:0] v, input int unsigned first,
                            input int unsigned last);
    for (int unsigned i = first; i <= last; i++) send_word(k, v[127-32*i -: 32]);
  endtask

  task automatic handoff();
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
  endtask

  initial begin
    // Reset state, with in_valid asserted during reset.
    do_reset();
    check("rst_blk_valid", blk_valid, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key", key, 0);
    check("rst_pt", plain_text, 0);
    check("rst_count", blk_count, 0);
    check("rst_in_ready", in_ready, 1);

    // 1: key then data, FIPS-197 vector.
    send_words(1'b1, K, 0, 3);
    check("t1_key_valid", key_valid, 1);
    check("t1_blk_valid_early", blk_valid, 0);
    send_words(1'b0, PT, 0, 3);
    check("t1_blk_valid", blk_valid, 1);
    check("t1_key", key, K);
    check("t1_pt", plain_text, PT);
    handoff();
    check("t1_blk_valid_after", blk_valid, 0);
    check("t1_count", blk_count, 1);
    check("t1_pt_hold", plain_text, PT);
    check("t1_in_ready_fill", in_ready, 1);

    // 2: data before key.
    do_reset();
    send_words(1'b0, PT2, 0, 3);
    check("t2_blk_valid_nokey", blk_valid, 0);
    in_is_key = 1'b0; #1;
    check("t2_in_ready_data", in_ready, 0);
    in_is_key = 1'b1; #1;
    check("t2_in_ready_key", in_ready, 1);
    send_words(1'b1, K, 0, 2);
    check("t2_blk_valid_3key", blk_valid, 0);
    send_words(1'b1, K, 3, 3);
    check("t2_blk_valid", blk_valid, 1);
    check("t2_pt", plain_text, PT2);
    handoff();
    check("t2_count", blk_count, 1);

    // 3: backpressure in HOLD.
    send_words(1'b0, PT, 0, 3);
    check("t3_blk_valid", blk_valid, 1);
    in_valid = 1'b1; in_data = 32'h5a5a5a5a;
    for (int i = 0; i < 5; i++) begin
      in_is_key = i[0];
      #1;
      check("t3_in_ready", in_ready, 0);
      check("t3_blk_valid_hold", blk_valid, 1);
      step();
      check("t3_pt_stable", plain_text, PT);
      check("t3_key_stable", key, K);
    end
    in_valid = 1'b0;
    handoff();
    check("t3_blk_valid_after", blk_valid, 0);
    in_is_key = 1'b0; #1;
    check("t3_in_ready_fill", in_ready, 1);
    check("t3_count", blk_count, 2);

    // 4: key word interleaved after data word 2.
    send_words(1'b0, PT4, 0, 1);
    send_words(1'b1, K4, 0, 0);
    check("t4_key_valid_clr", key_valid, 0);
    check("t4_key_slot0", key, {K4[127:96], K[95:0]});
    send_words(1'b0, PT4, 2, 3);
    check("t4_blk_valid_nokey", blk_valid, 0);
    send_words(1'b1, K4, 1, 3);
    check("t4_blk_valid", blk_valid, 1);
    check("t4_pt", plain_text, PT4);
    check("t4_key", key, K4);
    handoff();
    check("t4_count", blk_count, 3);

    // 5: reset after 3 data words.
    send_words(1'b0, PT2, 0, 2);
    do_reset();
    check("t5_pt_zero", plain_text, 0);
    check("t5_key_zero", key, 0);
    check("t5_key_valid", key_valid, 0);
    check("t5_count", blk_count, 0);
    send_words(1'b1, K, 0, 3);
    send_words(1'b0, PT5, 0, 3);
    check("t5_blk_valid", blk_valid, 1);
    check("t5_pt_fresh", plain_text, PT5);
    handoff();
    check("t5_count_after", blk_count, 1);

    // 6: two identical blocks with cipher feedback.
    do_reset();
    fb_cipher = CT;
    send_words(1'b1, K, 0, 3);
    send_words(1'b0, PT, 0, 3);
    check("t6_pt_blk1", plain_text, PT);
    handoff();
    send_words(1'b0, PT, 0, 3);
    check("t6_blk_valid2", blk_valid, 1);
`ifdef AES_LOADER_CBC_EN
    check("t6_pt_blk2", plain_text, PT ^ CT);
`else
    check("t6_pt_blk2", plain_text, PT);
`endif
    handoff();
    check("t6_count", blk_count, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream stage of the combinational AES-128 encryptor core.
- Accepts a 32-bit word stream with a valid/ready handshake and assembles the 128-bit key and the 128-bit plaintext block.
- Presents both as registered buses with a block-level valid/ready handshake to the logic wrapping the core.
- Bus bit order is [0:127]; the first word received occupies bits [0:31].

Parameters:
CNT_W, 16, width of the handed-off block counter (wraps modulo 2^CNT_W)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  loader accepts the word this cycle
in_data  input  32  input word, big-endian within the 128-bit bus
in_is_key  input  1  1 = key word, 0 = plaintext word
plain_text  output  128  assembled plaintext, bits [0:127], to the core
key  output  128  assembled key, bits [0:127], to the core
key_valid  output  1  all 4 words of the current key are loaded
blk_valid  output  1  plain_text/key pair valid for the core
blk_ready  input  1  downstream consumes the pair this cycle
fb_cipher  input  128  core cipher_text; used only with the optional feature
blk_count  output  CNT_W  number of blocks handed off

Behaviour:
- Transfer rules:
  - Word transfer = in_valid & in_ready.
  - Block transfer = blk_valid & blk_ready.
- States:
  - FILL: collecting plaintext words.
  - HOLD: 4 plaintext words held, waiting for hand-off.
- in_ready = (state==FILL) | (state==HOLD & in_is_key & ~key_valid). Purely combinational.
- Key load:
  - key_cnt (2 bits) selects slot key[32*key_cnt +: 32] in [0:127] order.
  - Accepting a key word with key_cnt==0 clears key_valid that cycle.
  - The 4th key word sets key_valid the next cycle; key_cnt wraps to 0.
  - Key words may be interleaved with data words in FILL; data_cnt is unaffected.
- Data load:
  - data_cnt selects the plaintext slot the same way.
  - The 4th data word transitions FILL->HOLD the next cycle; data_cnt returns to 0.
- blk_valid = (state==HOLD) & key_valid, registered-state based.
  - Latency: 4th data word accepted at edge N -> blk_valid high after edge N, if the key is already valid.
  - If the key is incomplete, blk_valid rises the cycle after the 4th key word.
- In HOLD, key_valid==1 forces in_ready=0 for all words. The key cannot change while blk_valid is high.
- Block transfer:
  - HOLD->FILL next cycle.
  - blk_count increments modulo 2^CNT_W.
  - plain_text and key hold their values until overwritten.
- blk_valid must stay high with stable buses until the transfer; blk_ready while blk_valid==0 has no effect.
- Reset values: state=FILL, key_cnt=0, data_cnt=0, key_valid=0, blk_valid=0, plain_text=0, key=0, blk_count=0, chain=0.
- Reset mid-operation discards partial words and any held block; the same-cycle in_valid is ignored.
- in_data with in_ready low is not captured.

Optional Feature:
- Macro: AES_LOADER_CBC_EN.
- Defined:
  - 128-bit chain register. On each block transfer it captures fb_cipher (the core output for the presented block).
  - Each plaintext word is stored XORed with the matching 32 bits of chain.
  - chain clears to 0 on reset and whenever a key word with key_cnt==0 is accepted. The first block after a key load is therefore plain ECB; the host XORs its IV into that first block.
- Undefined:
  - fb_cipher is ignored; no chain register is built.
  - Plain ECB assembly.

Test Plan:
1. Reset, then key words 00010203, 04050607, 08090a0b, 0c0d0e0f, then data 00112233, 44556677, 8899aabb, ccddeeff, blk_ready=1 -> blk_valid 1 cycle after last word. key=000102..0f, plain_text=00112233..eeff, core cipher 69c4e0d86a7b0430d8cdb78070b4c55a, blk_count=1.
2. Data words before key; key completes afterwards -> HOLD with blk_valid=0 and in_ready=1 only for key words. blk_valid rises the cycle after the 4th key word.
3. blk_ready held 0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, buses stable, blk_valid stays 1. Release -> transfer, FILL next cycle.
4. Key word interleaved after data word 2 -> data_cnt preserved. Key slot 0 updated, key_valid=0 until 3 more key words; block assembles correctly.
5. rst asserted after 3 data words -> all outputs zero next cycle. The next 4 data words form a fresh block.
6. With AES_LOADER_CBC_EN, same key, two identical plaintext blocks, fb_cipher from the core -> block 2 plain_text = pt XOR 69c4e0d86a7b0430d8cdb78070b4c55a. Without the macro, block 2 equals block 1.
